// File: rtl/btb_pkg.sv
// btb_pkg: shared definitions for the two-way branch target buffer.
//   - Default geometry and derived field positions.
//   - upd_op_e: action the retire-side update applies to the indexed set.
//   - Field extraction helpers (index, tag, target) and the predicted-PC
//     builder. Helpers take the geometry as arguments so one package serves
//     any parameterisation; callers size-cast the 64-bit results.
package btb_pkg;

  localparam int PC_W             = 64;
  localparam int NUM_WAYS         = 2;
  localparam int DEF_NUM_SETS     = 256;
  localparam int DEF_LOG_NUM_SETS = 8;
  localparam int DEF_TAG_LENGTH   = 10;
  localparam int DEF_TARGET_BITS  = 19;
  // Instructions are word aligned, so PC[1:0] never takes part in any field.
  localparam int INDEX_LSB        = 2;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_RETARGET,
    UPD_ALLOC,
    UPD_INVALIDATE
  } upd_op_e;

  function automatic logic [PC_W-1:0] low_mask(input int bits);
    return (64'd1 << bits) - 64'd1;
  endfunction

  function automatic logic [PC_W-1:0] btb_index(input logic [PC_W-1:0] pc,
                                                input int log_num_sets = DEF_LOG_NUM_SETS);
    return (pc >> INDEX_LSB) & low_mask(log_num_sets);
  endfunction

  function automatic logic [PC_W-1:0] btb_tag(input logic [PC_W-1:0] pc,
                                              input int log_num_sets = DEF_LOG_NUM_SETS,
                                              input int tag_length   = DEF_TAG_LENGTH);
    return (pc >> (log_num_sets + INDEX_LSB)) & low_mask(tag_length);
  endfunction

  function automatic logic [PC_W-1:0] btb_target_field(input logic [PC_W-1:0] pc,
                                                       input int target_bits = DEF_TARGET_BITS);
    return (pc >> INDEX_LSB) & low_mask(target_bits);
  endfunction

  // Predicted PC: upper bits come from the fetch PC itself, the stored
  // target supplies the low word-address bits.
  function automatic logic [PC_W-1:0] btb_expand(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] field,
                                                 input int target_bits = DEF_TARGET_BITS);
    return (pc & ~low_mask(target_bits + INDEX_LSB)) | (field << INDEX_LSB);
  endfunction

endpackage

// File: rtl/btb_way_match.sv
// btb_way_match: tag compare for one read of a two-way set.
// Ports:
//   valid[1:0]   valid bits of way 1 / way 0 in the read set
//   tag0, tag1   stored tags of way 0 / way 1
//   lookup_tag   tag of the PC being looked up
//   hit          some valid way holds lookup_tag
//   hit_way      matching way; way 0 wins if both match (0 when no hit)
module btb_way_match
  #(parameter int TAG_LENGTH = 10)
  (input  logic [1:0]            valid,
   input  logic [TAG_LENGTH-1:0] tag0,
   input  logic [TAG_LENGTH-1:0] tag1,
   input  logic [TAG_LENGTH-1:0] lookup_tag,
   output logic                  hit,
   output logic                  hit_way);

  logic match0;
  logic match1;

  assign match0  = valid[0] && (tag0 == lookup_tag);
  assign match1  = valid[1] && (tag1 == lookup_tag);
  assign hit     = match0 || match1;
  assign hit_way = !match0 && match1;

endmodule

// File: rtl/btb_2way.sv
// btb_2way: two-way set-associative BTB for a two-wide fetch stage.
// Ports:
//   clock, reset        posedge clock; asynchronous active-low reset
//   if_pc               slot 0 fetch PC; slot 1 is if_pc+4
//   if_flush            invalidate every entry at the next edge
//   rob_update*         retire-side correction (pc, target, taken)
//   if_hit0/1           per-slot hit
//   if_pred_addr0/1     per-slot predicted next PC (slot_pc+4 on miss)
// Lookups are combinational from registered state with no bypass of a
// same-cycle update. Storage is plain flop arrays behind three read ports
// (slot 0, slot 1, update) and one write port so it can move to SRAM.
module btb_2way
  import btb_pkg::*;
  #(parameter int NUM_SETS     = 256,
    parameter int LOG_NUM_SETS = 8,
    parameter int TAG_LENGTH   = 10,
    parameter int TARGET_BITS  = 19)
  (input  logic            clock,
   input  logic            reset,
   input  logic [PC_W-1:0] if_pc,
   input  logic            if_flush,
   input  logic            rob_update,
   input  logic [PC_W-1:0] rob_update_pc,
   input  logic [PC_W-1:0] rob_update_target,
   input  logic            rob_update_taken,
   output logic            if_hit0,
   output logic            if_hit1,
   output logic [PC_W-1:0] if_pred_addr0,
   output logic [PC_W-1:0] if_pred_addr1);

  typedef logic [LOG_NUM_SETS-1:0] idx_t;
  typedef logic [TAG_LENGTH-1:0]   tag_t;
  typedef logic [TARGET_BITS-1:0]  tgt_t;

  // Storage
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  tag_t                tag_q    [NUM_WAYS][NUM_SETS];
  tgt_t                target_q [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;

  // Slot 0 lookup
  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] pc2;
  idx_t idx0;
  tag_t tag0;
  logic hit0;
  logic way0;
  tgt_t tgt0;

  assign pc1  = if_pc + 64'd4;
  assign pc2  = if_pc + 64'd8;
  assign idx0 = LOG_NUM_SETS'(btb_index(if_pc, LOG_NUM_SETS));
  assign tag0 = TAG_LENGTH'(btb_tag(if_pc, LOG_NUM_SETS, TAG_LENGTH));

  btb_way_match #(.TAG_LENGTH(TAG_LENGTH)) u_match0
    (.valid(valid_q[idx0]), .tag0(tag_q[0][idx0]), .tag1(tag_q[1][idx0]),
     .lookup_tag(tag0), .hit(hit0), .hit_way(way0));

  assign tgt0 = target_q[way0][idx0];

  // Slot 1 lookup: index and tag come from the full incremented PC, so an
  // index wrap to set 0 carries into the tag and the upper bits.
  idx_t idx1;
  tag_t tag1;
  logic hit1;
  logic way1;
  tgt_t tgt1;

  assign idx1 = LOG_NUM_SETS'(btb_index(pc1, LOG_NUM_SETS));
  assign tag1 = TAG_LENGTH'(btb_tag(pc1, LOG_NUM_SETS, TAG_LENGTH));

  btb_way_match #(.TAG_LENGTH(TAG_LENGTH)) u_match1
    (.valid(valid_q[idx1]), .tag0(tag_q[0][idx1]), .tag1(tag_q[1][idx1]),
     .lookup_tag(tag1), .hit(hit1), .hit_way(way1));

  assign tgt1 = target_q[way1][idx1];

  assign if_hit0       = hit0;
  assign if_hit1       = hit1;
  assign if_pred_addr0 = hit0 ? btb_expand(if_pc, 64'(tgt0), TARGET_BITS) : pc1;
  assign if_pred_addr1 = hit1 ? btb_expand(pc1, 64'(tgt1), TARGET_BITS) : pc2;

  // Update port
  idx_t    upd_idx;
  tag_t    upd_tag;
  tgt_t    upd_field;
  logic    upd_hit;
  logic    upd_hit_way;
  logic    upd_victim;
  logic    upd_way;
  upd_op_e upd_op;

  assign upd_idx   = LOG_NUM_SETS'(btb_index(rob_update_pc, LOG_NUM_SETS));
  assign upd_tag   = TAG_LENGTH'(btb_tag(rob_update_pc, LOG_NUM_SETS, TAG_LENGTH));
  assign upd_field = TARGET_BITS'(btb_target_field(rob_update_target, TARGET_BITS));

  btb_way_match #(.TAG_LENGTH(TAG_LENGTH)) u_match_upd
    (.valid(valid_q[upd_idx]), .tag0(tag_q[0][upd_idx]), .tag1(tag_q[1][upd_idx]),
     .lookup_tag(upd_tag), .hit(upd_hit), .hit_way(upd_hit_way));

  // Fill an invalid way first (way 0 preferred); otherwise replace the LRU way.
  assign upd_victim = !valid_q[upd_idx][0] ? 1'b0 :
                      !valid_q[upd_idx][1] ? 1'b1 : lru_q[upd_idx];

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    upd_op  = UPD_NONE;
    upd_way = upd_hit_way;
    if (rob_update && !if_flush) begin
      if (rob_update_taken) begin
        if (upd_hit) begin
          upd_op = UPD_RETARGET;
        end else begin
          upd_op  = UPD_ALLOC;
          upd_way = upd_victim;
        end
      end else if (upd_hit) begin
        upd_op = UPD_INVALIDATE;
      end
    end
  end

  // Valid and LRU state. Lookup touches are written first so an update to
  // the same set, written later in the block, takes precedence. A flush
  // leaves LRU alone and suppresses both touches and the update.
  // NOTE: state uses non-blocking assignments so every read in this block
  // sees the pre-edge value and the last write to an element wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      lru_q <= '0;
    end else if (if_flush) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      if (hit0) lru_q[idx0] <= ~way0;
      if (hit1) lru_q[idx1] <= ~way1;
      case (upd_op)
        UPD_ALLOC: begin
          valid_q[upd_idx][upd_way] <= 1'b1;
          lru_q[upd_idx]            <= ~upd_way;
        end
        UPD_RETARGET: begin
          lru_q[upd_idx] <= ~upd_way;
        end
        UPD_INVALIDATE: begin
          valid_q[upd_idx][upd_way] <= 1'b0;
          lru_q[upd_idx]            <= upd_way;
        end
        default: ;
      endcase
    end
  end

  // Tag and target payload.
  // NOTE: payload arrays are deliberately not reset; valid gates every use,
  // and leaving them reset-free keeps them mappable onto SRAM.
  always_ff @(posedge clock) begin
    case (upd_op)
      UPD_ALLOC: begin
        tag_q[upd_way][upd_idx]    <= upd_tag;
        target_q[upd_way][upd_idx] <= upd_field;
      end
      UPD_RETARGET: begin
        target_q[upd_way][upd_idx] <= upd_field;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_btb_2way.sv
// tb_btb_2way: table-driven check of btb_2way. Each row is one cycle: the
// row's inputs are driven after a posedge, the expected lookup outputs
// (pre-update contents) are queued, then popped and compared at the negedge.
module tb_btb_2way;

  logic        clock;
  logic        reset;
  logic [63:0] if_pc;
  logic        if_flush;
  logic        rob_update;
  logic [63:0] rob_update_pc;
  logic [63:0] rob_update_target;
  logic        rob_update_taken;
  logic        if_hit0;
  logic        if_hit1;
  logic [63:0] if_pred_addr0;
  logic [63:0] if_pred_addr1;

  btb_2way dut
    (.clock(clock), .reset(reset), .if_pc(if_pc), .if_flush(if_flush),
     .rob_update(rob_update), .rob_update_pc(rob_update_pc),
     .rob_update_target(rob_update_target), .rob_update_taken(rob_update_taken),
     .if_hit0(if_hit0), .if_hit1(if_hit1),
     .if_pred_addr0(if_pred_addr0), .if_pred_addr1(if_pred_addr1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        upd;
    logic        taken;
    logic [63:0] upd_pc;
    logic [63:0] upd_tgt;
    logic        flush;
    logic [63:0] pc;
    logic        eh0;
    logic [63:0] ep0;
    logic        eh1;
    logic [63:0] ep1;
  } vec_t;

  typedef struct {
    logic        h0;
    logic [63:0] p0;
    logic        h1;
    logic [63:0] p1;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Lookup PC whose sets (0xFC, 0xFD) are never written.
  localparam logic [63:0] IDLE = 64'h3F0;
  localparam logic [63:0] IP0  = 64'h3F4;
  localparam logic [63:0] IP1  = 64'h3F8;
  // Three aliasing branches in set 0x10 plus a fourth for replacement.
  localparam logic [63:0] PA = 64'h10040;
  localparam logic [63:0] PB = 64'h20040;
  localparam logic [63:0] PC = 64'h30040;
  localparam logic [63:0] PD = 64'h40040;

  function automatic vec_t mk(input logic upd, input logic taken,
                              input logic [63:0] upd_pc, input logic [63:0] upd_tgt,
                              input logic flush, input logic [63:0] pc,
                              input logic eh0, input logic [63:0] ep0,
                              input logic eh1, input logic [63:0] ep1);
    vec_t v;
    v.upd = upd; v.taken = taken; v.upd_pc = upd_pc; v.upd_tgt = upd_tgt;
    v.flush = flush; v.pc = pc;
    v.eh0 = eh0; v.ep0 = ep0; v.eh1 = eh1; v.ep1 = ep1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push_exp(input logic h0, input logic [63:0] p0,
                          input logic h1, input logic [63:0] p1);
    exp_t e;
    e.h0 = h0; e.p0 = p0; e.h1 = h1; e.p1 = p1;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, " hit0"},  64'(if_hit0), 64'(e.h0));
      check({name, " pred0"}, if_pred_addr0, e.p0);
      check({name, " hit1"},  64'(if_hit1), 64'(e.h1));
      check({name, " pred1"}, if_pred_addr1, e.p1);
    end
  endtask

  // Entered #1 after a posedge; leaves #1 after the next posedge.
  task automatic apply(input vec_t v, input string name);
    rob_update        = v.upd;
    rob_update_taken  = v.taken;
    rob_update_pc     = v.upd_pc;
    rob_update_target = v.upd_tgt;
    if_flush          = v.flush;
    if_pc             = v.pc;
    push_exp(v.eh0, v.ep0, v.eh1, v.ep1);
    @(negedge clock);
    compare_out(name);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // upd taken upd_pc upd_tgt flush pc | hit0 pred0 hit1 pred1
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 0,64'h1004, 0,64'h1008));          // 0 reset state
    vecs.push_back(mk(1,1,64'h1004,64'h2000,0, 64'h1000, 0,64'h1004, 0,64'h1008)); // 1 install slot1 pc
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 0,64'h1004, 1,64'h2000));          // 2 slot1 hit
    vecs.push_back(mk(1,1,64'h1000,64'h2000,0, IDLE, 0,IP0, 0,IP1));          // 3 install 0x1000
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 1,64'h2000, 1,64'h2000));          // 4
    vecs.push_back(mk(1,1,64'h1000,64'h3000,0, 64'h1000, 1,64'h2000, 1,64'h2000)); // 5 retarget, old seen
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 1,64'h3000, 1,64'h2000));          // 6 new target
    vecs.push_back(mk(1,0,64'h1000,0,0, IDLE, 0,IP0, 0,IP1));                 // 7 not-taken evict
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 0,64'h1004, 1,64'h2000));          // 8
    vecs.push_back(mk(1,0,64'h5000,0,0, IDLE, 0,IP0, 0,IP1));                 // 9 not-taken miss
    vecs.push_back(mk(0,0,0,0,0, 64'h5000, 0,64'h5004, 0,64'h5008));          // 10
    vecs.push_back(mk(1,1,PA,64'h4000,0, IDLE, 0,IP0, 0,IP1));                // 11 A -> way0
    vecs.push_back(mk(1,1,PB,64'h5000,0, IDLE, 0,IP0, 0,IP1));                // 12 B -> way1
    vecs.push_back(mk(1,1,PC,64'h6000,0, IDLE, 0,IP0, 0,IP1));                // 13 C evicts A
    vecs.push_back(mk(0,0,0,0,0, PA, 0,PA+4, 0,PA+8));                        // 14
    vecs.push_back(mk(0,0,0,0,0, PB, 1,64'h5000, 0,PB+8));                    // 15
    vecs.push_back(mk(0,0,0,0,0, PC, 1,64'h6000, 0,PC+8));                    // 16
    vecs.push_back(mk(1,1,64'h12_0020_0000,64'h12_0031_2340,0, IDLE, 0,IP0, 0,IP1)); // 17 wrap entry
    vecs.push_back(mk(0,0,0,0,0, 64'h12_001F_FFFC, 0,64'h12_0020_0000, 1,64'h12_0031_2340)); // 18 wrap
    vecs.push_back(mk(0,0,0,0,0, 64'h13_0020_0000, 1,64'h13_0031_2340, 0,64'h13_0020_0008)); // 19 upper bits
    vecs.push_back(mk(1,1,64'h7000,64'h8000,1, IDLE, 0,IP0, 0,IP1));          // 20 flush + update
    vecs.push_back(mk(0,0,0,0,0, 64'h7000, 0,64'h7004, 0,64'h7008));          // 21 update dropped
    vecs.push_back(mk(0,0,0,0,0, PB, 0,PB+4, 0,PB+8));                        // 22 flushed
    vecs.push_back(mk(0,0,0,0,0, 64'h1000, 0,64'h1004, 0,64'h1008));          // 23 flushed
    vecs.push_back(mk(1,1,PA,64'h4000,0, IDLE, 0,IP0, 0,IP1));                // 24 A -> way0
    vecs.push_back(mk(1,1,PB,64'h5000,0, IDLE, 0,IP0, 0,IP1));                // 25 B -> way1
    vecs.push_back(mk(0,0,0,0,0, PA, 1,64'h4000, 0,PA+8));                    // 26 touch: lru -> way1
    vecs.push_back(mk(1,1,PC,64'h6000,0, IDLE, 0,IP0, 0,IP1));                // 27 C evicts B
    vecs.push_back(mk(0,0,0,0,0, PB, 0,PB+4, 0,PB+8));                        // 28
    vecs.push_back(mk(0,0,0,0,0, PA, 1,64'h4000, 0,PA+8));                    // 29
    vecs.push_back(mk(0,0,0,0,0, PC, 1,64'h6000, 0,PC+8));                    // 30
    vecs.push_back(mk(1,1,PC,64'h6000,0, PA, 1,64'h4000, 0,PA+8));            // 31 update beats touch
    vecs.push_back(mk(1,1,PD,64'h9000,0, IDLE, 0,IP0, 0,IP1));                // 32 D evicts A
    vecs.push_back(mk(0,0,0,0,0, PA, 0,PA+4, 0,PA+8));                        // 33
    vecs.push_back(mk(0,0,0,0,0, PC, 1,64'h6000, 0,PC+8));                    // 34
    vecs.push_back(mk(0,0,0,0,0, PD, 1,64'h9000, 0,PD+8));                    // 35

    reset = 1'b0; if_pc = 64'h1000; if_flush = 1'b0; rob_update = 1'b0;
    rob_update_pc = '0; rob_update_target = '0; rob_update_taken = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Reset asserted mid-cycle with an update pending: state clears at once
    // and the update never lands.
    rob_update = 1'b1; rob_update_taken = 1'b1;
    rob_update_pc = 64'h50040; rob_update_target = 64'hA000;
    if_pc = PD;
    #2;
    reset = 1'b0;
    #1;
    push_exp(0, PD+4, 0, PD+8);
    compare_out("in_reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rob_update = 1'b0;
    @(posedge clock);
    #1;
    apply(mk(0,0,0,0,0, 64'h50040, 0,64'h50044, 0,64'h50048), "reset_lost_update");
    apply(mk(0,0,0,0,0, PC, 0,PC+4, 0,PC+8), "reset_cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
